// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and segment codes for the digit scan controller
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Segment order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;

endpackage

// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - BCD nibble to seven-segment pattern, non-decimal nibbles blank
module seven_segment_decoder
  import seg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller with frame-aligned value updates
// Optional leading-zero blanking: define SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic                    ready,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pend_q, pend_d;
  logic                    ready_q, frame_q;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    accept, wrap, blank;
  logic [3:0]              nib;
  logic [6:0]              dec_seg;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    wrap     = 1'b0;
    accept   = load && ready_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          disp_d  = value_in;
          state_d = SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = SHOW;
          cnt_d   = '0;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept && state_q != IDLE) begin
      shadow_d = value_in;
      pend_d   = 1'b1;
    end
    // A value captured on the wrap edge itself stays pending for the following frame.
    if (wrap && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end
  end

  // Outputs are registered, so decode looks at next-state index and display value.
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) nib = disp_d[4*i +: 4];
    end
  end

  seven_segment_decoder u_dec (
    .bcd (nib),
    .seg (dec_seg)
  );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (disp_d[4*i +: 4] != 4'h0) msd = IDX_W'(i);
    end
    blank = (idx_d > msd);
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_d = SEG_BLANK;
    en_d  = '0;
    if (state_d == SHOW) begin
      en_d  = NUM_DIGITS'(1) << idx_d;
      seg_d = blank ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      ready_q  <= 1'b1;
      frame_q  <= 1'b0;
      seg_q    <= SEG_BLANK;
      en_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      ready_q  <= !pend_d;
      frame_q  <= wrap;
      seg_q    <= seg_d;
      en_q     <= en_d;
    end
  end

  assign ready      = ready_q;
  assign seg        = seg_q;
  assign digit_en   = en_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl (4 digits, 4-cycle show, 1-cycle gap)
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GC = 1;
  localparam int FRAME = ND * (RD + GC);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b0000000;
`else
  localparam logic [6:0] LZ = 7'b1111110;
`endif

  typedef struct packed {
    logic [3:0] en;
    logic [6:0] seg;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value_in = 16'h0;
  logic          ready;
  logic [6:0]    seg;
  logic [ND-1:0] digit_en;
  logic          frame_done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GAP_CYCLES(GC)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value_in   (value_in),
    .ready      (ready),
    .seg        (seg),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    sb_q.push_back('{en: 4'b0001, seg: s0});
    sb_q.push_back('{en: 4'b0010, seg: s1});
    sb_q.push_back('{en: 4'b0100, seg: s2});
    sb_q.push_back('{en: 4'b1000, seg: s3});
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    value_in = v;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 3 * FRAME);
    if (!frame_done) chk("frame_done_timeout", 16'd0, 16'd1);
  endtask

  // Monitor: pops one expectation per display window and checks timing around it.
  logic [ND-1:0] mon_prev_en;
  exp_t          mon_cur;
  int            mon_win_len, mon_gap_len, mon_fd_cnt;
  bit            mon_in_win, mon_gap_ok, mon_fd_ok;

  initial begin
    mon_prev_en = '0;
    mon_in_win = 0; mon_gap_ok = 0; mon_fd_ok = 0;
    mon_win_len = 0; mon_gap_len = 0; mon_fd_cnt = 0;
    mon_cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev_en = '0;
        mon_in_win = 0; mon_gap_ok = 0; mon_fd_ok = 0;
        continue;
      end
      if (digit_en != '0) begin
        if (mon_prev_en == '0) begin
          if (mon_gap_ok) chk("gap_length", 16'(mon_gap_len), 16'(GC));
          if (sb_q.size() == 0) begin
            chk("unexpected_window", 16'(digit_en), 16'h0);
            mon_cur = '0;
          end else begin
            mon_cur = sb_q.pop_front();
          end
          mon_in_win = 1;
          mon_win_len = 0;
        end
        mon_win_len++;
        chk("window_digit_en", 16'(digit_en), 16'(mon_cur.en));
        chk("window_seg", 16'(seg), 16'(mon_cur.seg));
      end else begin
        if (mon_in_win) begin
          chk("show_length", 16'(mon_win_len), 16'(RD));
          mon_in_win = 0;
          mon_gap_ok = 1;
          mon_gap_len = 0;
        end
        mon_gap_len++;
        chk("gap_seg_off", 16'(seg), 16'h0);
      end
      if (frame_done) begin
        chk("frame_done_digit", 16'(digit_en), 16'b0001);
        if (mon_fd_ok) chk("frame_period", 16'(mon_fd_cnt), 16'(FRAME));
        mon_fd_ok = 1;
        mon_fd_cnt = 0;
      end
      mon_fd_cnt++;
      mon_prev_en = digit_en;
    end
  end

  initial begin
    int n;
    #2 rst = 1'b1;
    #1;
    chk("rst_seg", 16'(seg), 16'h0);
    chk("rst_digit_en", 16'(digit_en), 16'h0);
    chk("rst_ready", 16'(ready), 16'h1);
    chk("rst_frame_done", 16'(frame_done), 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", 16'(ready), 16'h1);
      chk("idle_digit_en", 16'(digit_en), 16'h0);
    end

    // 1234 from IDLE, shown on the very next cycle
    push_frame(7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000);
    do_load(16'h1234);
    @(negedge clk);
    chk("first_digit_en", 16'(digit_en), 16'b0001);
    chk("first_seg", 16'(seg), 16'b0110011);
    chk("first_ready", 16'(ready), 16'h1);
    chk("first_no_frame_done", 16'(frame_done), 16'h0);
    push_frame(7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000);
    wait_fd();

    // 5678 mid-frame; a later load while busy must be dropped
    repeat (6) @(negedge clk);
    chk("mid_ready_before", 16'(ready), 16'h1);
    do_load(16'h5678);
    @(negedge clk);
    chk("mid_ready_after", 16'(ready), 16'h0);
    do_load(16'h9999);
    push_frame(7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011);
    wait_fd();
    chk("commit_ready", 16'(ready), 16'h1);
    chk("commit_digit_en", 16'(digit_en), 16'b0001);
    chk("commit_seg", 16'(seg), 16'b1111111);

    // non-decimal nibble blanks but keeps its digit enabled
    repeat (2) @(negedge clk);
    do_load(16'h12A4);
    @(negedge clk);
    do_load(16'h8888);
    push_frame(7'b0110011, 7'b0000000, 7'b1101101, 7'b0110000);
    wait_fd();

    do_load(16'h0042);
    push_frame(7'b1101101, 7'b0110011, LZ, LZ);
    wait_fd();

    do_load(16'h0000);
    push_frame(7'b1111110, LZ, LZ, LZ);
    wait_fd();

    // reset during a GAP with a pending value
    do_load(16'h7777);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (digit_en != '0 && n < 2 * FRAME);
    chk("found_gap", 16'(digit_en), 16'h0);
    chk("pending_ready", 16'(ready), 16'h0);
    rst = 1'b1;
    #1;
    chk("midrst_seg", 16'(seg), 16'h0);
    chk("midrst_digit_en", 16'(digit_en), 16'h0);
    chk("midrst_ready", 16'(ready), 16'h1);
    chk("midrst_frame_done", 16'(frame_done), 16'h0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_digit_en", 16'(digit_en), 16'h0);
      chk("postrst_ready", 16'(ready), 16'h1);
    end

    push_frame(7'b1111011, LZ, LZ, LZ);
    do_load(16'h0009);
    push_frame(7'b1111011, LZ, LZ, LZ);
    wait_fd();
    n = 0;
    while (sb_q.size() != 0 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 16'(sb_q.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
